// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit shifter (SLL/SRL/SRA/ROR)
// with a single registered result slot that supports backpressure.
module shift_arbiter #(
    parameter int W  = 32,
    parameter int SH = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic [7:0]   busy_cnt
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    function automatic logic [W-1:0] shift_op(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [SH-1:0] s);
        logic [2*W-1:0] dbl;
        // Rotate by shifting a doubled copy; s=0 naturally returns a.
        dbl = {a, a} >> s;
        case (op)
            OP_SLL:  return a << s;
            OP_SRL:  return a >> s;
            OP_SRA:  return $signed(a) >>> s;
            default: return dbl[W-1:0];
        endcase
    endfunction

    logic           req_valid [2];
    logic [1:0]     req_op    [2];
    logic [W-1:0]   req_a     [2];
    logic [SH-1:0]  req_s     [2];
    logic [W-1:0]   shift_res [2];

    assign req_valid[0] = req0_valid;
    assign req_valid[1] = req1_valid;
    assign req_op[0]    = req0_op;
    assign req_op[1]    = req1_op;
    assign req_a[0]     = req0_a;
    assign req_a[1]     = req1_a;
    assign req_s[0]     = req0_b[SH-1:0];
    assign req_s[1]     = req1_b[SH-1:0];

    // Upper amount bits are deliberately ignored.
    logic unused_b_hi;
    assign unused_b_hi = ^{req0_b[W-1:SH], req1_b[W-1:SH]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_shift
            assign shift_res[gi] = shift_op(req_op[gi], req_a[gi], req_s[gi]);
        end
    endgenerate

    logic         resp_valid_reg, resp_valid_next;
    logic         resp_id_reg, resp_id_next;
    logic [W-1:0] resp_data_reg, resp_data_next;
    logic [7:0]   busy_cnt_reg, busy_cnt_next;
    logic         rr_last_reg, rr_last_next;
    logic         can_accept;
    logic [1:0]   grant;

    // A requester loses a tie only if it was the most recent winner.
    assign can_accept = !resp_valid_reg || resp_ready;
    assign grant[0]   = can_accept && req_valid[0] && (!req_valid[1] || rr_last_reg);
    assign grant[1]   = can_accept && req_valid[1] && (!req_valid[0] || !rr_last_reg);

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        resp_valid_next = resp_valid_reg;
        resp_id_next    = resp_id_reg;
        resp_data_next  = resp_data_reg;
        rr_last_next    = rr_last_reg;
        busy_cnt_next   = busy_cnt_reg;
        if (grant[0] || grant[1]) begin
            resp_valid_next = 1'b1;
            resp_id_next    = grant[1];
            resp_data_next  = grant[1] ? shift_res[1] : shift_res[0];
            rr_last_next    = grant[1];
        end else if (resp_ready) begin
            resp_valid_next = 1'b0;
        end
        if (resp_valid_reg && !resp_ready && busy_cnt_reg != 8'hFF) begin
            busy_cnt_next = busy_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_data_reg  <= '0;
            busy_cnt_reg   <= 8'd0;
            rr_last_reg    <= 1'b1;
        end else begin
            resp_valid_reg <= resp_valid_next;
            resp_id_reg    <= resp_id_next;
            resp_data_reg  <= resp_data_next;
            busy_cnt_reg   <= busy_cnt_next;
            rr_last_reg    <= rr_last_next;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_data  = resp_data_reg;
    assign busy_cnt   = busy_cnt_reg;

endmodule
